// File: rtl/parking_exit_ctrl.sv
// Exit-lane gate controller: opens the gate for a departing car, closes it once the car
// has cleared, and keeps the lot occupancy count with full/empty status for the entrance side.
module parking_exit_ctrl #(
   parameter int unsigned CAPACITY     = 8,
   parameter int unsigned CNT_W        = 4,
   parameter int unsigned OPEN_DELAY   = 3,
   parameter int unsigned PASS_TIMEOUT = 50
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             exit_sensor_input,
   input  logic             exit_back_sensor_input,
   input  logic             car_admitted,
   output logic             exit_gate_open,
   output logic             EXIT_GREEN_LED,
   output logic             EXIT_RED_LED,
   output logic [CNT_W-1:0] occupancy,
   output logic             lot_full,
   output logic             lot_empty,
   output logic             fault
);

   localparam int unsigned DLY_W = 4;
   localparam int unsigned TO_W  = 8;

   localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);
   localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(OPEN_DELAY - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(PASS_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_OPEN_WAIT,
      S_PASSING,
      S_CLOSING,
      S_FAULT
   } state_t;

   state_t           state, state_nxt;
   logic [DLY_W-1:0] dly_cnt, dly_nxt;
   logic [TO_W-1:0]  to_cnt, to_nxt;
   logic [CNT_W-1:0] occ_nxt;
   logic             occ_dec, occ_inc;

   // Next-state and counter logic; the delay counter is loaded with OPEN_DELAY-1 so
   // OPEN_WAIT lasts exactly OPEN_DELAY cycles.
   always_comb begin
      state_nxt = state;
      dly_nxt   = dly_cnt;
      to_nxt    = to_cnt;
      case (state)
         S_IDLE: begin
            if (exit_sensor_input) begin
               if (occupancy != '0) begin
                  state_nxt = S_OPEN_WAIT;
                  dly_nxt   = DLY_LOAD;
               end else begin
                  state_nxt = S_FAULT;
               end
            end
         end
         S_OPEN_WAIT: begin
            if (dly_cnt == '0) begin
               state_nxt = S_PASSING;
               to_nxt    = '0;
            end else begin
               dly_nxt = dly_cnt - DLY_W'(1);
            end
         end
         S_PASSING: begin
            if (exit_back_sensor_input && !exit_sensor_input) begin
               state_nxt = S_CLOSING;
            end else if (to_cnt == TO_LAST) begin
               state_nxt = S_FAULT;
            end else begin
               to_nxt = to_cnt + TO_W'(1);
            end
         end
         S_CLOSING: state_nxt = S_IDLE;
         S_FAULT: begin
            if (!exit_sensor_input && !exit_back_sensor_input) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Occupancy: an admit coinciding with the exit decrement cancels it out.
   always_comb begin
      occ_dec = (state == S_CLOSING) && (occupancy != '0);
      occ_inc = car_admitted && (occupancy != CAP);
      occ_nxt = occupancy;
      if (occ_dec && !car_admitted) begin
         occ_nxt = occupancy - CNT_W'(1);
      end else if (occ_inc && !occ_dec) begin
         occ_nxt = occupancy + CNT_W'(1);
      end
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         dly_cnt        <= '0;
         to_cnt         <= '0;
         exit_gate_open <= 1'b0;
         EXIT_GREEN_LED <= 1'b0;
         EXIT_RED_LED   <= 1'b0;
         fault          <= 1'b0;
         occupancy      <= '0;
         lot_full       <= 1'b0;
         lot_empty      <= 1'b1;
      end else begin
         state          <= state_nxt;
         dly_cnt        <= dly_nxt;
         to_cnt         <= to_nxt;
         exit_gate_open <= (state_nxt == S_OPEN_WAIT) || (state_nxt == S_PASSING);
         EXIT_GREEN_LED <= (state_nxt == S_PASSING);
         EXIT_RED_LED   <= (state_nxt == S_OPEN_WAIT) || (state_nxt == S_CLOSING) ||
                           (state_nxt == S_FAULT);
         fault          <= (state_nxt == S_FAULT);
         occupancy      <= occ_nxt;
         lot_full       <= (occ_nxt == CAP);
         lot_empty      <= (occ_nxt == '0);
      end
   end

endmodule

// File: tb/tb_parking_exit_ctrl.sv
// Directed bench for parking_exit_ctrl: each step pushes the expected output word to a
// scoreboard queue, clocks the DUT, then pops and compares it against the outputs.
module tb_parking_exit_ctrl;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             exit_sensor_input;
   logic             exit_back_sensor_input;
   logic             car_admitted;
   logic             exit_gate_open;
   logic             EXIT_GREEN_LED;
   logic             EXIT_RED_LED;
   logic [CNT_W-1:0] occupancy;
   logic             lot_full;
   logic             lot_empty;
   logic             fault;

   typedef struct {
      string      tag;
      logic [9:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   parking_exit_ctrl #(
      .CAPACITY(8), .CNT_W(CNT_W), .OPEN_DELAY(3), .PASS_TIMEOUT(50)
   ) dut (
      .clk                    (clk),
      .reset_n                (reset_n),
      .exit_sensor_input      (exit_sensor_input),
      .exit_back_sensor_input (exit_back_sensor_input),
      .car_admitted           (car_admitted),
      .exit_gate_open         (exit_gate_open),
      .EXIT_GREEN_LED         (EXIT_GREEN_LED),
      .EXIT_RED_LED           (EXIT_RED_LED),
      .occupancy              (occupancy),
      .lot_full               (lot_full),
      .lot_empty              (lot_empty),
      .fault                  (fault)
   );

   always #5 clk = ~clk;

   // Expected word {gate, green, red, fault, full, empty, occupancy}
   function automatic logic [9:0] ev(input logic g, input logic gr, input logic r,
                                     input logic f, input int occ);
      logic [3:0] o;
      o = 4'(occ);
      return {g, gr, r, f, (occ == 8), (occ == 0), o};
   endfunction

   function automatic logic [9:0] obs();
      return {exit_gate_open, EXIT_GREEN_LED, EXIT_RED_LED, fault, lot_full, lot_empty, occupancy};
   endfunction

   task automatic check(input string tag, input logic [9:0] expected);
      logic [9:0] observed;
      observed = obs();
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   // Drive inputs, queue the expectation, clock once, pop and compare.
   task automatic step(input logic es, input logic bs, input logic adm,
                       input logic [9:0] expected, input string tag);
      exp_t e;
      exit_sensor_input      = es;
      exit_back_sensor_input = bs;
      car_admitted           = adm;
      e.tag = tag;
      e.val = expected;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check(e.tag, e.val);
   endtask

   initial begin
      reset_n                = 1'b0;
      exit_sensor_input      = 1'b0;
      exit_back_sensor_input = 1'b0;
      car_admitted           = 1'b0;
      #100;
      check("reset", ev(0, 0, 0, 0, 0));
      @(negedge clk);
      reset_n = 1'b1;
      step(0, 0, 0, ev(0, 0, 0, 0, 0), "idle_after_reset");

      // Exit request on an empty lot faults without opening the gate
      step(1, 0, 0, ev(0, 0, 1, 1, 0), "empty_fault");
      step(1, 0, 0, ev(0, 0, 1, 1, 0), "empty_fault_hold");
      step(0, 1, 0, ev(0, 0, 1, 1, 0), "empty_fault_back");
      step(0, 0, 0, ev(0, 0, 0, 0, 0), "empty_fault_clear");

      // Admit two, then one car exits normally
      step(0, 0, 1, ev(0, 0, 0, 0, 1), "admit1");
      step(0, 0, 1, ev(0, 0, 0, 0, 2), "admit2");
      step(1, 0, 0, ev(1, 0, 1, 0, 2), "open_wait1");
      step(1, 0, 0, ev(1, 0, 1, 0, 2), "open_wait2");
      step(1, 0, 0, ev(1, 0, 1, 0, 2), "open_wait3");
      step(1, 0, 0, ev(1, 1, 0, 0, 2), "green");
      step(0, 1, 0, ev(0, 0, 1, 0, 2), "closing");
      step(0, 0, 0, ev(0, 0, 0, 0, 1), "exit_done");

      // Timeout: car never reaches the back sensor
      step(1, 0, 0, ev(1, 0, 1, 0, 1), "to_open_wait1");
      step(1, 0, 0, ev(1, 0, 1, 0, 1), "to_open_wait2");
      step(1, 0, 0, ev(1, 0, 1, 0, 1), "to_open_wait3");
      step(1, 0, 0, ev(1, 1, 0, 0, 1), "to_passing");
      for (int i = 1; i < 50; i++) begin
         step(1, 0, 0, ev(1, 1, 0, 0, 1), $sformatf("to_passing_%0d", i));
      end
      step(1, 0, 0, ev(0, 0, 1, 1, 1), "timeout_fault");
      step(1, 0, 0, ev(0, 0, 1, 1, 1), "timeout_fault_hold");
      step(0, 0, 0, ev(0, 0, 0, 0, 1), "timeout_clear");

      // Saturation: eight more admits, the last one dropped at capacity
      for (int i = 2; i <= 9; i++) begin
         step(0, 0, 1, ev(0, 0, 0, 0, (i > 8) ? 8 : i), $sformatf("admit_sat_%0d", i));
      end

      // Exit at capacity with an admit during CLOSING, then a back-to-back car
      step(1, 0, 0, ev(1, 0, 1, 0, 8), "full_open_wait1");
      step(1, 0, 0, ev(1, 0, 1, 0, 8), "full_open_wait2");
      step(1, 0, 0, ev(1, 0, 1, 0, 8), "full_open_wait3");
      step(1, 0, 0, ev(1, 1, 0, 0, 8), "full_green");
      step(0, 1, 0, ev(0, 0, 1, 0, 8), "full_closing");
      step(1, 0, 1, ev(0, 0, 0, 0, 8), "admit_in_closing");
      step(1, 0, 0, ev(1, 0, 1, 0, 8), "back_to_back_open");
      step(1, 0, 0, ev(1, 0, 1, 0, 8), "b2b_open_wait2");
      step(1, 0, 0, ev(1, 0, 1, 0, 8), "b2b_open_wait3");
      step(1, 0, 0, ev(1, 1, 0, 0, 8), "b2b_green");

      // Asynchronous reset while green
      #3;
      reset_n = 1'b0;
      #1;
      check("async_reset_mid_pass", ev(0, 0, 0, 0, 0));
      @(negedge clk);
      reset_n = 1'b1;
      step(0, 0, 0, ev(0, 0, 0, 0, 0), "after_async_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
